// File: rtl/ad9228_tx_pkg.sv
// ad9228_tx_pkg: shared constants and state type for the AD9228 transmit gearbox.
package ad9228_tx_pkg;
  localparam int BYTE_WIDTH = 8;
  localparam int SR_WIDTH_DEFAULT = 32;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} tx_state_t;
endpackage

// File: rtl/ad9228_tx_gearbox.sv
// ad9228_tx_gearbox: packs DATA_WIDTH-bit words into an MSB-first byte stream with word-MSB frame marks.
module ad9228_tx_gearbox
  import ad9228_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int SR_WIDTH = SR_WIDTH_DEFAULT
) (
  input  logic                  data_out_clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  output logic                  data_ready_out,
  input  logic                  flush_in,
  output logic [7:0]            data_out,
  output logic                  data_valid_out,
  output logic [7:0]            frame_mark_out,
  output logic                  pad_out
);
  localparam int CW = $clog2(SR_WIDTH + 1);
  localparam logic [CW-1:0] BW = CW'(BYTE_WIDTH);
  logic [SR_WIDTH-1:0] data_q, mark_q, keep_data, keep_mark, data_d, mark_d;
  logic [CW-1:0] bit_count, rem, next_count;
  logic flush_pending, flush_pending_d, run, pop, push, in_flush;
  tx_state_t state, state_d;
  assign in_flush = state == FLUSH;
  assign pop = bit_count >= BW;
  assign rem = pop ? bit_count - BW : bit_count;
  // run holds ready low while reset is asserted without looking at rstn combinationally
  assign data_ready_out = run && !flush_pending && (int'(rem) + DATA_WIDTH <= SR_WIDTH);
  assign push = data_valid_in && data_ready_out;
  assign keep_data = data_q & ({SR_WIDTH{1'b1}} >> (SR_WIDTH - int'(rem)));
  assign keep_mark = mark_q & ({SR_WIDTH{1'b1}} >> (SR_WIDTH - int'(rem)));
  assign data_d = push ? (keep_data << DATA_WIDTH) | SR_WIDTH'(data_in) : keep_data;
  assign mark_d = push ? (keep_mark << DATA_WIDTH) | (SR_WIDTH'(1) << (DATA_WIDTH - 1)) : keep_mark;
  assign next_count = in_flush ? '0 : push ? rem + CW'(DATA_WIDTH) : rem;
  assign flush_pending_d = !in_flush && next_count != '0 &&
                           (flush_pending || (flush_in && (bit_count != '0 || push)));
  always_comb begin
    state_d = IDLE;
    state_d = flush_pending_d && next_count < BW ? FLUSH : next_count >= BW ? STREAM : IDLE;
  end
  always_ff @(posedge data_out_clk or negedge rstn) begin
    if (!rstn) begin
      run <= 1'b0;
      bit_count <= '0;
      flush_pending <= 1'b0;
      state <= IDLE;
      data_q <= '0;
      mark_q <= '0;
      data_out <= '0;
      frame_mark_out <= '0;
      data_valid_out <= 1'b0;
      pad_out <= 1'b0;
    end else begin
      run <= 1'b1;
      bit_count <= next_count;
      flush_pending <= flush_pending_d;
      state <= state_d;
      data_q <= in_flush ? '0 : data_d;
      mark_q <= in_flush ? '0 : mark_d;
      data_valid_out <= pop || in_flush;
      pad_out <= in_flush;
      if (pop) begin
        data_out <= 8'(data_q >> rem);
        frame_mark_out <= 8'(mark_q >> rem);
      end else if (in_flush) begin
        data_out <= 8'(data_q << (BYTE_WIDTH - int'(bit_count)));
        frame_mark_out <= 8'(mark_q << (BYTE_WIDTH - int'(bit_count)));
      end
    end
  end
endmodule

// File: tb/tb_ad9228_tx_gearbox.sv
// tb_ad9228_tx_gearbox: bit-queue reference model plus directed and random stimulus for the tx gearbox.
module tb_ad9228_tx_gearbox;
  localparam int DW = 12;
  localparam int SR = 32;
  logic clk = 1'b0, rstn = 1'b0, vin = 1'b0, fin = 1'b0, ready, vout, pad;
  logic [DW-1:0] din = '0;
  logic [7:0] dout, fmark;
  int vectors = 0, errors = 0, cyc = 0;
  bit qd[$], qm[$];
  bit m_fp, m_fc, m_run, last_push;
  logic [7:0] e_byte, e_mark;
  logic e_valid, e_pad;
  logic [7:0] cap_b[$], cap_m[$];
  bit cap_p[$];
  int cap_c[$];

  ad9228_tx_gearbox #(.DATA_WIDTH(DW), .SR_WIDTH(SR)) dut (
    .data_out_clk(clk), .rstn(rstn), .data_in(din), .data_valid_in(vin),
    .data_ready_out(ready), .flush_in(fin), .data_out(dout),
    .data_valid_out(vout), .frame_mark_out(fmark), .pad_out(pad)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_ready();
    int r = qd.size() >= 8 ? qd.size() - 8 : qd.size();
    return m_run && !m_fp && (r + DW <= SR);
  endfunction

  task automatic model_reset();
    qd.delete(); qm.delete();
    m_fp = 0; m_fc = 0; m_run = 0;
    e_byte = '0; e_mark = '0; e_valid = 1'b0; e_pad = 1'b0;
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] w, input bit f);
    int n0;
    vin = v; din = w; fin = f;
    #1 chk("ready", ready, m_ready());
    last_push = v && m_ready();
    n0 = qd.size();
    if (m_fc) begin
      e_byte = '0; e_mark = '0;
      for (int i = 0; i < qd.size(); i++) begin
        e_byte[7-i] = qd[i];
        e_mark[7-i] = qm[i];
      end
      qd.delete(); qm.delete();
      e_valid = 1'b1; e_pad = 1'b1; m_fp = 0; m_fc = 0;
    end else begin
      e_valid = n0 >= 8;
      e_pad = 1'b0;
      if (e_valid)
        for (int i = 0; i < 8; i++) begin
          e_byte[7-i] = qd.pop_front();
          e_mark[7-i] = qm.pop_front();
        end
      if (last_push)
        for (int i = DW - 1; i >= 0; i--) begin
          qd.push_back(w[i]);
          qm.push_back(i == DW - 1);
        end
      if (f && (n0 > 0 || last_push)) m_fp = 1;
      if (m_fp && qd.size() == 0) m_fp = 0;
      m_fc = m_fp && qd.size() > 0 && qd.size() < 8;
    end
    m_run = 1;
    @(posedge clk);
    #1;
    cyc++;
    chk("valid", vout, e_valid);
    chk("data", dout, e_byte);
    chk("mark", fmark, e_mark);
    chk("pad", pad, e_pad);
    if (vout) begin
      cap_b.push_back(dout); cap_m.push_back(fmark); cap_p.push_back(pad); cap_c.push_back(cyc);
    end
    @(negedge clk);
    vin = 1'b0; fin = 1'b0;
  endtask

  task automatic clear_cap();
    cap_b.delete(); cap_m.delete(); cap_p.delete(); cap_c.delete();
  endtask

  initial begin
    logic [7:0] exp6 [9] = '{8'h00, 8'h10, 8'h02, 8'h00, 8'h30, 8'h04, 8'h00, 8'h50, 8'h06};
    logic [DW-1:0] sent[$];
    logic [DW-1:0] acc;
    int rw[$], nb, acc_win, val_win, tries;
    model_reset();
    #1;
    chk("rst_data", dout, 8'h00);
    chk("rst_valid", vout, 1'b0);
    chk("rst_mark", fmark, 8'h00);
    chk("rst_pad", pad, 1'b0);
    chk("rst_ready", ready, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    cycle(0, '0, 0);

    // two back-to-back words
    clear_cap();
    cycle(1, 12'hABC, 0);
    cycle(1, 12'hDEF, 0);
    cycle(0, '0, 0);
    cycle(0, '0, 0);
    chk("t1_nbytes", cap_b.size(), 3);
    if (cap_b.size() == 3) begin
      chk("t1_b0", cap_b[0], 8'hAB); chk("t1_b1", cap_b[1], 8'hCD); chk("t1_b2", cap_b[2], 8'hEF);
      chk("t1_m0", cap_m[0], 8'h80); chk("t1_m1", cap_m[1], 8'h08); chk("t1_m2", cap_m[2], 8'h00);
      chk("t1_gap", cap_c[2] - cap_c[0], 2);
    end

    // single word then flush
    clear_cap();
    cycle(1, 12'h123, 0);
    cycle(0, '0, 1);
    chk("t2_ready_low", ready, 1'b0);
    cycle(0, '0, 0);
    chk("t2_ready_back", ready, 1'b1);
    chk("t2_nbytes", cap_b.size(), 2);
    if (cap_b.size() == 2) begin
      chk("t2_b0", cap_b[0], 8'h12); chk("t2_m0", cap_m[0], 8'h80); chk("t2_p0", cap_p[0], 1'b0);
      chk("t2_b1", cap_b[1], 8'h30); chk("t2_m1", cap_m[1], 8'h00); chk("t2_p1", cap_p[1], 1'b1);
    end

    // six incrementing words with valid held high
    clear_cap();
    for (int k = 1; k <= 6; k++) cycle(1, DW'(k), 0);
    for (int k = 0; k < 6; k++) cycle(0, '0, 0);
    chk("t3_nbytes", cap_b.size(), 9);
    if (cap_b.size() == 9) begin
      chk("t3_nogap", cap_c[8] - cap_c[0], 8);
      for (int k = 0; k < 9; k++) chk("t3_byte", cap_b[k], exp6[k]);
    end

    // flush on an empty block
    clear_cap();
    cycle(0, '0, 1);
    cycle(0, '0, 0);
    chk("t4_nbytes", cap_b.size(), 0);
    chk("t4_ready", ready, 1'b1);

    // sustained input settles to 2 accepts per 3 cycles with no output bubble
    acc_win = 0; val_win = 0;
    for (int k = 0; k < 60; k++) begin
      cycle(1, DW'($urandom), 0);
      if (k >= 30) begin
        acc_win += int'(last_push);
        val_win += int'(vout);
      end
    end
    chk("t5_accepts", acc_win, 20);
    chk("t5_valid", val_win, 30);
    for (int k = 0; k < 8; k++) cycle(0, '0, 0);

    // asynchronous reset with 4 residual bits
    cycle(1, 12'hABC, 0);
    cycle(0, '0, 0);
    #2 rstn = 1'b0;
    #1;
    chk("t6_data", dout, 8'h00);
    chk("t6_valid", vout, 1'b0);
    chk("t6_mark", fmark, 8'h00);
    chk("t6_pad", pad, 1'b0);
    chk("t6_ready", ready, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    clear_cap();
    cycle(0, '0, 0);
    cycle(1, 12'h456, 0);
    cycle(0, '0, 0);
    cycle(0, '0, 0);
    chk("t6_nbytes", cap_b.size(), 1);
    if (cap_b.size() == 1) begin
      chk("t6_b0", cap_b[0], 8'h45);
      chk("t6_m0", cap_m[0], 8'h80);
    end

    // random gaps, reconstruct words from the byte stream using the frame marks
    clear_cap();
    tries = 0;
    while (sent.size() < 1000 && tries < 20000) begin
      logic [DW-1:0] w = DW'($urandom);
      bit v = $urandom_range(0, 9) < 7;
      cycle(v, w, 0);
      if (last_push) sent.push_back(w);
      tries++;
    end
    chk("t7_sent", sent.size(), 1000);
    cycle(0, '0, 1);
    for (int k = 0; k < 8; k++) cycle(0, '0, 0);
    nb = -1; acc = '0;
    foreach (cap_b[k])
      for (int b = 7; b >= 0; b--) begin
        if (cap_m[k][b]) begin nb = 0; acc = '0; end
        if (nb >= 0 && nb < DW) begin
          acc = {acc[DW-2:0], cap_b[k][b]};
          nb++;
          if (nb == DW) begin rw.push_back(int'(acc)); nb = -1; end
        end
      end
    chk("t7_nwords", rw.size(), sent.size());
    for (int k = 0; k < rw.size() && k < sent.size(); k++) chk("t7_word", rw[k], sent[k]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
